// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap sequencer: FSM states, default
// sizes and the circular delay-line address function.
package fir_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned TAPS_DEF   = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RUN,
    ST_DRAIN
  } fir_state_e;

  // Ring address of tap k; callers truncate to their address width for the wrap.
  function automatic logic [31:0] ring_addr(input logic [31:0] wptr, input logic [31:0] k);
    return wptr - k;
  endfunction

endpackage

// File: rtl/fir_tap_cnt.sv
// Tap counter plus the one-cycle strobe delay that lines the MAC controls up
// with the RAM read latency.
module fir_tap_cnt
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            run_i,
  output logic [ADDR_W:0] k_o,
  output logic            run_done_c_o,
  output logic            mac_en_o,
  output logic            mac_clr_o,
  output logic            mac_last_o
);

  localparam int unsigned   KW     = ADDR_W + 1;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  logic [KW-1:0] k_q;
  logic          mac_en_q;
  logic          mac_clr_q;
  logic          mac_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
    end else begin
      if (start_i) begin
        k_q <= '0;
      end else if (run_i) begin
        k_q <= k_q + KW'(1);
      end
      // RAM data for tap k appears one cycle after its address.
      mac_en_q   <= run_i;
      mac_clr_q  <= run_i && (k_q == '0);
      mac_last_q <= run_i && (k_q == K_LAST);
    end
  end

  assign k_o          = k_q;
  assign run_done_c_o = run_i && (k_q == K_LAST);
  assign mac_en_o     = mac_en_q;
  assign mac_clr_o    = mac_clr_q;
  assign mac_last_o   = mac_last_q;

endmodule

// File: rtl/fir_tap_seq.sv
// FIR tap sequencer: writes each accepted sample into the ring, then walks all
// taps driving sample/coef RAM addresses. FIR_TAP_SEQ_COEF_LOAD_EN adds an
// idle-time coefficient write port.
module fir_tap_seq
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [DATA_W-1:0] smp_din,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              mac_last,
  output logic              busy
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
  ,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_wr_addr,
  input  logic [DATA_W-1:0] coef_wr_data,
  output logic              coef_ram_we,
  output logic [DATA_W-1:0] coef_ram_din
`endif
);

  fir_state_e        state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] smp_addr_q;
  logic [ADDR_W-1:0] coef_addr_q;
  logic [DATA_W-1:0] smp_din_q;
  logic              smp_we_q;
  logic              in_ready_q;
  logic [ADDR_W:0]   k;
  logic              run_done_c;
  logic              start_c;
  logic              run_c;
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
  logic              coef_ram_we_q;
  logic [DATA_W-1:0] coef_ram_din_q;
`endif

  assign start_c = (state_q == ST_WRITE);
  assign run_c   = (state_q == ST_RUN);

  fir_tap_cnt #(
    .ADDR_W (ADDR_W),
    .TAPS   (TAPS)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_c),
    .run_i        (run_c),
    .k_o          (k),
    .run_done_c_o (run_done_c),
    .mac_en_o     (mac_en),
    .mac_clr_o    (mac_clr),
    .mac_last_o   (mac_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      in_ready_q  <= 1'b1;
      smp_we_q    <= 1'b0;
      smp_addr_q  <= '0;
      smp_din_q   <= '0;
      coef_addr_q <= '0;
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
      coef_ram_we_q  <= 1'b0;
      coef_ram_din_q <= '0;
`endif
    end else begin
      smp_we_q <= 1'b0;
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
      coef_ram_we_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
          // Coefficient writes win over a new sample in the same cycle.
          if (coef_we) begin
            coef_ram_we_q  <= 1'b1;
            coef_addr_q    <= coef_wr_addr;
            coef_ram_din_q <= coef_wr_data;
          end else
`endif
          if (in_valid) begin
            state_q    <= ST_WRITE;
            in_ready_q <= 1'b0;
            smp_we_q   <= 1'b1;
            smp_addr_q <= wptr_q;
            smp_din_q  <= in_data;
          end
        end
        ST_WRITE: begin
          state_q     <= ST_RUN;
          smp_addr_q  <= ADDR_W'(ring_addr(32'(wptr_q), 32'd0));
          coef_addr_q <= '0;
        end
        ST_RUN: begin
          if (run_done_c) begin
            state_q <= ST_DRAIN;
          end else begin
            smp_addr_q  <= ADDR_W'(ring_addr(32'(wptr_q), 32'(k) + 32'd1));
            coef_addr_q <= ADDR_W'(32'(k) + 32'd1);
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_IDLE;
          wptr_q     <= wptr_q + ADDR_W'(1);
          in_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
  // A pending coefficient write must hold off the sample handshake this cycle.
  assign in_ready     = in_ready_q & ~coef_we;
  assign coef_ram_we  = coef_ram_we_q;
  assign coef_ram_din = coef_ram_din_q;
`else
  assign in_ready     = in_ready_q;
`endif
  assign busy      = ~in_ready;
  assign smp_we    = smp_we_q;
  assign smp_addr  = smp_addr_q;
  assign smp_din   = smp_din_q;
  assign coef_addr = coef_addr_q;

endmodule

// File: tb/tb_fir_tap_seq.sv
// Bench for fir_tap_seq (ADDR_W=3, TAPS=4): external RAM/MAC models, a
// sample-history reference model and a per-cycle compare process.
module tb_fir_tap_seq;

  localparam int unsigned DW    = 24;
  localparam int unsigned AW    = 3;
  localparam int          TAPS  = 4;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, smp_we, mac_en, mac_clr, mac_last, busy;
  logic [AW-1:0] smp_addr, coef_addr;
  logic [DW-1:0] smp_din;
  logic          cwe_m;
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_wr_addr = '0;
  logic [DW-1:0] coef_wr_data = '0;
  logic          coef_ram_we;
  logic [DW-1:0] coef_ram_din;
  assign cwe_m = coef_we;
`else
  assign cwe_m = 1'b0;
`endif

  fir_tap_seq #(.DATA_W(DW), .ADDR_W(AW), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .smp_we(smp_we), .smp_addr(smp_addr), .smp_din(smp_din), .coef_addr(coef_addr),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .busy(busy)
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .coef_ram_we(coef_ram_we), .coef_ram_din(coef_ram_din)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // External RAMs and MAC the sequencer drives.
  logic [DW-1:0] sram [DEPTH] = '{default: '0};
  logic [DW-1:0] cram [DEPTH] = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd0, 24'd0, 24'd0, 24'd0};
  logic [DW-1:0] s_rd = '0, c_rd = '0;
  longint        acc = 0;

  always @(posedge clk) begin
    if (smp_we) sram[smp_addr] <= smp_din;
    s_rd <= sram[smp_addr];
    c_rd <= cram[coef_addr];
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
    if (coef_ram_we) cram[coef_addr] <= coef_ram_din;
`endif
    if (mac_en) acc <= mac_clr ? longint'(s_rd) * longint'(c_rd)
                               : acc + longint'(s_rd) * longint'(c_rd);
  end

  // Reference model: sample history in ring positions, phase since accept.
  logic [DW-1:0] mring [DEPTH] = '{default: '0};
  int            mcoef [DEPTH] = '{1, 2, 3, 4, 0, 0, 0, 0};
  int            ph = 0, mw = 0, cyc = 0;
  logic [DW-1:0] exp_x = '0;
  longint        exp_y = 0;
  logic          y_pend = 1'b0;
  int            acc_log[$];
  logic          cw_pend = 1'b0;
  logic [AW-1:0] cw_addr = '0;
  logic [DW-1:0] cw_data = '0;

  function automatic longint calc_y(input logic [DW-1:0] xn);
    longint s = 0;
    longint x;
    for (int k = 0; k < TAPS; k++) begin
      x = (k == 0) ? longint'(xn) : longint'(mring[(mw - k + DEPTH) % DEPTH]);
      s += x * longint'(mcoef[k]);
    end
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; mw <= 0; y_pend <= 1'b0; cw_pend <= 1'b0;
    end else begin
      y_pend  <= 1'b0;
      cw_pend <= (ph == 0) && cwe_m;
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
      cw_addr <= coef_wr_addr;
      cw_data <= coef_wr_data;
`endif
      if (ph == 0) begin
        if (in_valid && !cwe_m) begin
          ph <= 1;
          mring[mw] <= in_data;
          exp_x <= in_data;
          exp_y <= calc_y(in_data);
          acc_log.push_back(cyc);
        end
      end else if (ph == TAPS + 2) begin
        ph <= 0;
        mw <= (mw + 1) % DEPTH;
        y_pend <= 1'b1;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  // Per-cycle compare against the model.
  int     addr_log[$], coefa_log[$], wr_log[$];
  longint y_log[$];
  int     clr_cnt = 0, last_cnt = 0;

  always @(negedge clk) begin
    int k;
    logic rdy;
    if (rst_n) begin
      rdy = (ph == 0) && !cwe_m;
      chk("in_ready", in_ready, rdy);
      chk("busy", busy, !rdy);
      chk("smp_we", smp_we, ph == 1);
      chk("mac_en", mac_en, (ph >= 3) && (ph <= TAPS + 2));
      chk("mac_clr", mac_clr, ph == 3);
      chk("mac_last", mac_last, ph == TAPS + 2);
      if (mac_clr) clr_cnt++;
      if (mac_last) last_cnt++;
      if (ph == 1) begin
        chk("wr_addr", smp_addr, mw);
        chk("wr_data", smp_din, exp_x);
        wr_log.push_back(int'(smp_addr));
      end
      if (ph >= 2 && ph <= TAPS + 1) begin
        k = ph - 2;
        chk("rd_addr", smp_addr, (mw - k + DEPTH) % DEPTH);
        chk("coef_addr", coef_addr, k);
        addr_log.push_back(int'(smp_addr));
        coefa_log.push_back(int'(coef_addr));
      end
      if (y_pend) begin
        chk("mac_result", acc, exp_y);
        y_log.push_back(acc);
      end
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
      chk("coef_ram_we", coef_ram_we, cw_pend);
      if (cw_pend) begin
        chk("coef_wr_addr_out", coef_addr, cw_addr);
        chk("coef_wr_data_out", coef_ram_din, cw_data);
      end
`endif
    end
  end

  task automatic wait_accept(input int n0);
    int n = 0;
    while (acc_log.size() == n0 && n < 30) begin @(posedge clk); #1; n++; end
    if (acc_log.size() == n0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ph != 0 && n < 30) begin @(posedge clk); #1; n++; end
    if (ph != 0) chk("idle_timeout", ph, 0);
    @(negedge clk); #1;
  endtask

  task automatic send(input int d, input bit cw_mid);
    int n0;
    @(posedge clk); #1;
    n0 = acc_log.size();
    in_valid = 1'b1; in_data = DW'(d);
    wait_accept(n0);
    in_valid = 1'b0;
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
    if (cw_mid) begin
      @(posedge clk); #1;
      coef_we = 1'b1; coef_wr_addr = 3'd2; coef_wr_data = 24'd99;
      @(posedge clk); #1;
      @(posedge clk); #1;
      coef_we = 1'b0;
    end
`else
    if (cw_mid) @(posedge clk);
`endif
    wait_idle();
  endtask

  int exp_a[4];
  int exp_c[4];

  initial begin
    int n0;
    #12;
    chk("rst_in_ready", in_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_smp_we", smp_we, 0);     chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_clr", mac_clr, 0);   chk("rst_mac_last", mac_last, 0);
    chk("rst_smp_addr", smp_addr, 0); chk("rst_smp_din", smp_din, 0);
    chk("rst_coef_addr", coef_addr, 0);
    #5 rst_n = 1'b1;

    // Impulse through coefficients 1,2,3,4.
    send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    chk("impulse_y_count", y_log.size(), 4);
    if (y_log.size() == 4) begin
      chk("impulse_y0", y_log[0], 1); chk("impulse_y1", y_log[1], 2);
      chk("impulse_y2", y_log[2], 3); chk("impulse_y3", y_log[3], 4);
    end
    chk("clr_once_each", clr_cnt, 4);
    chk("last_once_each", last_cnt, 4);

    // Fifth sample, wptr=4.
    addr_log.delete(); coefa_log.delete();
    send(7, 0);
    exp_a = '{4, 3, 2, 1}; exp_c = '{0, 1, 2, 3};
    chk("addr_seq_len", addr_log.size(), 4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("addr_seq_smp", addr_log[i], exp_a[i]);
        chk("addr_seq_coef", coefa_log[i], exp_c[i]);
      end
    chk("fifth_wr_addr", wr_log[$], 4);
    chk("fifth_y", y_log[$], 7);

    // Ninth sample wraps to address 0.
    send(2, 0); send(3, 0); send(4, 0);
    addr_log.delete();
    send(5, 0);
    exp_a = '{0, 7, 6, 5};
    chk("wrap_wr_addr", wr_log[$], 0);
    chk("wrap_len", addr_log.size(), 4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_rd_addr", addr_log[i], exp_a[i]);
    chk("wrap_y", y_log[$], 30);

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    n0 = acc_log.size();
    in_valid = 1'b1; in_data = 24'd11;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_log.size() - n0 == 1) in_data = 24'd12;
      if (acc_log.size() - n0 == 2) in_data = 24'd13;
      if (acc_log.size() - n0 >= 3) break;
    end
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_count", acc_log.size() - n0, 3);
    if (acc_log.size() - n0 == 3) begin
      chk("b2b_gap0", acc_log[n0 + 1] - acc_log[n0], TAPS + 3);
      chk("b2b_gap1", acc_log[n0 + 2] - acc_log[n0 + 1], TAPS + 3);
    end

    // Reset pulse in the middle of RUN.
    @(posedge clk); #1;
    n0 = acc_log.size();
    in_valid = 1'b1; in_data = 24'd9;
    wait_accept(n0);
    in_valid = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    n0 = last_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1); chk("abort_busy", busy, 0);
    chk("abort_mac_en", mac_en, 0);     chk("abort_mac_last", mac_last, 0);
    chk("abort_mac_clr", mac_clr, 0);   chk("abort_smp_addr", smp_addr, 0);
    chk("abort_coef_addr", coef_addr, 0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_no_last", last_cnt, n0);
    send(6, 0);
    chk("post_reset_wr_addr", wr_log[$], 0);

    // Zero the span, then an impulse (with a coefficient load when enabled).
    send(0, 0); send(0, 0); send(0, 0);
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
    @(posedge clk); #1;
    coef_we = 1'b1; coef_wr_addr = 3'd2; coef_wr_data = 24'd5;
    in_valid = 1'b1; in_data = 24'd1;
    mcoef[2] = 5;
    @(posedge clk); #1;
    coef_we = 1'b0;
`endif
    send(1, 0); send(0, 1); send(0, 0);
`ifdef FIR_TAP_SEQ_COEF_LOAD_EN
    chk("coef_load_y", y_log[$], 5);
`else
    chk("rom_coef_y", y_log[$], 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
